gen_processing_element: RTL and testbench

// - Pipelined signed multiply-accumulate processing element: o_psum = i_x * i_w + i_psum.
// - Building block of a systolic/MAC array. Accepts a new operand set every cycle, with no

---
 rtl/pe_pkg.sv | 25 ++
 rtl/pe_delay_line.sv | 33 +++
 rtl/gen_processing_element.sv | 97 +++++++++
 tb/tb_gen_processing_element.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared widths and arithmetic helpers for the processing-element array.
package pe_pkg;

  localparam int XW_DEF  = 8;
  localparam int WW_DEF  = 8;
  localparam int BW1_DEF = 16;
  localparam int BW2_DEF = 17;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clamp a signed value into the range of a width-bit two's complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/pe_delay_line.sv
// Reset-to-zero shift register of depth L; L=0 degenerates to a wire.
module pe_delay_line
  import pe_pkg::*;
#(
  parameter int W = 17,
  parameter int L = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (L == 0) begin : g_bypass
    assign q = d;
  end else begin : g_line
    for (genvar i = 0; i < L; i++) begin : g_stage
      logic [W-1:0] r;
      logic [W-1:0] prev;
      if (i == 0) begin : g_first
        assign prev = d;
      end else begin : g_next
        assign prev = g_line.g_stage[i-1].r;
      end
      always_ff @(posedge i_clk) begin
        if (i_rst) r <= '0;
        else       r <= prev;
      end
    end
    assign q = g_line.g_stage[L-1].r;
  end

endmodule

// File: rtl/gen_processing_element.sv
// Pipelined signed MAC: o_psum = i_x * i_w + i_psum, depth D, saturating when BW2 is narrow.
module gen_processing_element
  import pe_pkg::*;
#(
  parameter int BW1 = BW1_DEF,
  parameter int BW2 = BW2_DEF,
  parameter int N   = 17,
  parameter int XW  = XW_DEF,
  parameter int WW  = WW_DEF,
  parameter int D   = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic signed [XW-1:0]  i_x,
  input  logic signed [WW-1:0]  i_w,
  input  logic signed [BW1-1:0] i_psum,
  output logic signed [BW2-1:0] o_psum
);

  localparam int S = max_int(N, BW1) + 1;

  // The S-bit sum is exact; only the final fit to BW2 can lose range, and it clamps.
  function automatic logic signed [BW2-1:0] fit_out(input logic signed [S-1:0] v);
    if (BW2 >= S) return BW2'(v);
    return BW2'(sat_signed(64'(v), BW2));
  endfunction

  function automatic logic signed [N-1:0] mult(input logic signed [XW-1:0] x,
                                               input logic signed [WW-1:0] w);
    return N'(x) * N'(w);
  endfunction

  function automatic logic signed [BW2-1:0] add_fit(input logic signed [N-1:0]   prod,
                                                    input logic signed [BW1-1:0] psum);
    return fit_out(S'(prod) + S'(psum));
  endfunction

  if (D == 1) begin : g_d1
    logic signed [BW2-1:0] sum_p0;
    always_ff @(posedge i_clk) begin
      if (i_rst) sum_p0 <= '0;
      else       sum_p0 <= add_fit(mult(i_x, i_w), i_psum);
    end
    assign o_psum = sum_p0;
  end else begin : g_multi
    // stage p0: operand registers
    logic signed [XW-1:0]  x_p0;
    logic signed [WW-1:0]  w_p0;
    logic signed [BW1-1:0] psum_p0;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        x_p0    <= '0;
        w_p0    <= '0;
        psum_p0 <= '0;
      end else begin
        x_p0    <= i_x;
        w_p0    <= i_w;
        psum_p0 <= i_psum;
      end
    end

    if (D == 2) begin : g_d2
      logic signed [BW2-1:0] sum_p1;
      always_ff @(posedge i_clk) begin
        if (i_rst) sum_p1 <= '0;
        else       sum_p1 <= add_fit(mult(x_p0, w_p0), psum_p0);
      end
      assign o_psum = sum_p1;
    end else begin : g_d3
      // stage p1: product, psum carried alongside
      logic signed [N-1:0]   prod_p1;
      logic signed [BW1-1:0] psum_p1;
      logic signed [BW2-1:0] sum_p2;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          prod_p1 <= '0;
          psum_p1 <= '0;
        end else begin
          prod_p1 <= mult(x_p0, w_p0);
          psum_p1 <= psum_p0;
        end
      end
      // stage p2: saturated sum
      always_ff @(posedge i_clk) begin
        if (i_rst) sum_p2 <= '0;
        else       sum_p2 <= add_fit(prod_p1, psum_p1);
      end
      pe_delay_line #(.W(BW2), .L(D - 3)) u_delay (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .d     (sum_p2),
        .q     (o_psum)
      );
    end
  end

endmodule

// File: tb/tb_gen_processing_element.sv
// Scoreboard bench: five PE variants share stimulus; each cycle's expected output is queued per DUT.
module tb_gen_processing_element;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [7:0]   x = '0;
  logic signed [7:0]   w = '0;
  logic signed [15:0]  p = '0;
  logic signed [16:0]  o_d1, o_d2, o_d3, o_d5;
  logic signed [15:0]  o_s16;

  always #5 clk = ~clk;

  gen_processing_element #(.D(1)) u_d1 (.i_clk(clk), .i_rst(rst), .i_x(x), .i_w(w), .i_psum(p), .o_psum(o_d1));
  gen_processing_element #(.D(2)) u_d2 (.i_clk(clk), .i_rst(rst), .i_x(x), .i_w(w), .i_psum(p), .o_psum(o_d2));
  gen_processing_element #(.D(3)) u_d3 (.i_clk(clk), .i_rst(rst), .i_x(x), .i_w(w), .i_psum(p), .o_psum(o_d3));
  gen_processing_element #(.D(5)) u_d5 (.i_clk(clk), .i_rst(rst), .i_x(x), .i_w(w), .i_psum(p), .o_psum(o_d5));
  gen_processing_element #(.D(3), .BW2(16)) u_s16 (.i_clk(clk), .i_rst(rst), .i_x(x), .i_w(w), .i_psum(p), .o_psum(o_s16));

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t sb [5][$];
  int   edge_n   = 0;
  int   checks   = 0;
  int   failures = 0;

  function automatic int depth(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      3:       return 5;
      default: return 3;
    endcase
  endfunction

  function automatic logic signed [31:0] actual(input int i);
    case (i)
      0:       return 32'(o_d1);
      1:       return 32'(o_d2);
      2:       return 32'(o_d3);
      3:       return 32'(o_d5);
      default: return 32'(o_s16);
    endcase
  endfunction

  function automatic string dut_name(input int i);
    case (i)
      0:       return "D1";
      1:       return "D2";
      2:       return "D3";
      3:       return "D5";
      default: return "D3_BW16";
    endcase
  endfunction

  // Monitor: after every counted rising edge, retire whatever is due this cycle.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      while (sb[i].size() > 0 && sb[i][0].cyc <= edge_n) begin
        e = sb[i].pop_front();
        checks++;
        if (e.cyc < edge_n) begin
          failures++;
          $display("FAIL %s missed_slot cyc=%0d now=%0d", dut_name(i), e.cyc, edge_n);
        end else if (actual(i) !== e.val) begin
          failures++;
          $display("FAIL %s o_psum cyc=%0d got=%0d expected=%0d", dut_name(i), edge_n,
                   actual(i), e.val);
        end
      end
    end
  end

  // One operand set for one edge; e17/e16 are the hand-computed results for BW2=17/16.
  task automatic step(input bit r, input int xv, input int wv, input int pv,
                      input int e17, input int e16);
    int k;
    @(negedge clk);
    rst = r;
    x   = 8'(xv);
    w   = 8'(wv);
    p   = 16'(pv);
    k   = edge_n + 1;
    for (int i = 0; i < 5; i++) begin
      if (r) begin
        while (sb[i].size() > 0 && sb[i][$].cyc >= k) void'(sb[i].pop_back());
        for (int j = 0; j < depth(i); j++) sb[i].push_back('{cyc: k + j, val: 0});
      end else begin
        sb[i].push_back('{cyc: k + depth(i) - 1, val: (i == 4) ? e16 : e17});
      end
    end
    @(posedge clk);
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_reset();
    step(1'b1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
         int'($urandom_range(0, 65535)) - 32768, 0, 0);
  endtask

  initial begin
    rand_reset();
    rand_reset();
    idle(5);

    step(1'b0, 100, 50, 100, 5100, 5100);
    step(1'b0, 10, 16, 5, 165, 165);
    step(1'b0, 20, 50, 1, 1001, 1001);
    idle(6);

    step(1'b0, -128, -128, 32767, 49151, 32767);
    step(1'b0, -128, 127, -32768, -49024, -32768);
    step(1'b0, 127, 127, -1, 16128, 16128);
    step(1'b0, -1, 1, 0, -1, -1);
    idle(6);

    step(1'b0, 1, 1, 0, 1, 1);
    idle(7);

    step(1'b0, 100, 50, 100, 5100, 5100);
    step(1'b0, 10, 16, 5, 165, 165);
    step(1'b0, 20, 50, 1, 1001, 1001);
    rand_reset();
    idle(7);
    step(1'b0, 1, 1, 0, 1, 1);
    idle(7);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
